uart_rx_oversampled: RTL and testbench
======================================

Name: uart_rx_oversampled

Overview:
- UART receiver, 8N1, LSB first. Sits directly downstream of the baud tick generator.
- Drives the generator's `enable` and consumes its oversampled `tick`. Mid-bit samples the asynchronous `rx` line.
- Emits one byte per frame to the fabric, e.g. the eurorack-pmod debug/control command path.

Parameters:
- OVERSAMPLING, 8, ticks per bit period. Must be even and ≥4. Tick generator is instantiated with the same value.
- SYNC_STAGES, 2, flip-flops in the `rx` metastability synchroniser. Must be ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx  in  1  asynchronous serial input; idle high.
- tick_en  out  1  to the tick generator `enable`. Low holds the generator accumulator at its preset phase.
- tick  in  1  oversampled baud tick from the generator, single-cycle pulse.
- data  out  8  last good byte. Held until the next good frame.
- valid  out  1  one-cycle pulse when `data` updates.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (applied on any clk edge with rst=1, including mid-frame):
  - synchroniser chain all 1; state IDLE; tick_en 0.
  - data 8'h00; valid 0; frame_err 0; busy 0.
  - tick counter 0; bit counter 0; shift register 0.
- rx_s is the output of the SYNC_STAGES-flop chain. All decisions use rx_s only.
- Tick counter is $clog2(OVERSAMPLING) bits wide. It increments only on cycles with tick=1 and is cleared on every state transition.
- IDLE: tick_en=0. If rx_s=0, go to START next cycle with tick_en=1.
- START: on the tick where the counter reaches OVERSAMPLING/2-1 (mid start bit), sample rx_s.
  - rx_s=1: glitch. Return to IDLE; no outputs pulse.
  - rx_s=0: go to DATA; bit counter=0.
- DATA: on the tick where the counter reaches OVERSAMPLING-1, sample rx_s.
  - Shift right: shift <= {rx_s, shift[7:1]}. Bit counter increments.
  - After bit counter 7 is sampled, go to STOP.
- STOP: on the tick where the counter reaches OVERSAMPLING-1, sample rx_s.
  - rx_s=1: data<=shift, valid=1 for exactly one cycle, go to IDLE.
  - rx_s=0: frame_err=1 for one cycle, data unchanged, go to BREAK.
- BREAK: tick_en=0. Stay until rx_s=1, then go to IDLE. A held-low line therefore never produces repeated frames.
- tick_en is high only in START, DATA and STOP. It is registered in the same cycle as the state register.
- Timing and corner cases:
  - The first tick can arrive any time after tick_en rises; timing is counted only in ticks, never in clocks.
  - A tick arriving in the same cycle as a state transition counts for the new state's counter only if the state is START, DATA or STOP. Otherwise it is ignored.
  - If tick stays low, the FSM waits indefinitely with no timeout.
  - valid and frame_err are never high in the same cycle.
  - Latency: valid rises one clk after the tick at the stop-bit sample point.

Decomposition:
- Shared package uart_pkg holds:
  - state enum: IDLE, START, DATA, STOP, BREAK.
  - localparam DATA_BITS=8.
  - default OVERSAMPLING=8, shared with the tick generator instantiation.
- One natural sub-module: `sync_ff`, a SYNC_STAGES-deep flop chain with reset value 1.
- Tick generator is instantiated by the parent, not inside this block. This keeps one generator shareable with a TX sharing the same baud.

Test Plan:
- Common setup: clk=12 MHz; generator set to baud=115200, oversampling=8, enable driven by tick_en.
- Byte 0xA5 with stop=1 → exactly one valid pulse; data=8'hA5; frame_err never high; busy low afterwards.
- rx low for 2 tick periods only → return to IDLE from START; no valid or frame_err; busy pulses then falls.
- Byte 0x3C with stop=0, then rx held low for 40 bit-times → one frame_err pulse; data retains previous 8'hA5; no further pulses until rx goes high. A following 0x55 frame → valid with data=8'h55.
- Back-to-back 0x00 then 0xFF, with stop immediately followed by start → two valid pulses; data 8'h00 then 8'hFF; no frame_err.
- rst asserted for 1 clk at bit 4 of 0x81, rx then returned high → all outputs at reset values; no valid; the next 0x81 frame is received correctly.
- Tick stall: bench gates tick to 0 for 1000 clks during DATA → state and counters frozen; frame completes correctly once ticks resume.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and framing constants,
// also used when instantiating the shared baud tick generator.
package uart_pkg;
  localparam int DATA_BITS        = 8;
  localparam int OVERSAMPLING_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;
endpackage

// File: rtl/uart_rx_oversampled_sync_ff.sv
// Metastability synchroniser for an asynchronous input; resets to 1 so an
// idle-high line never looks like a start bit coming out of reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '1;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver, LSB first, timed purely by the oversampled baud tick.
// Drives the external tick generator's enable while a frame is in progress.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int OVERSAMPLING = OVERSAMPLING_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tick_en,
  input  logic                 tick,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int CW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLING/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_rx_state_t       state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bitcnt;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // The sampling tick is consumed by the state that samples; only a tick
  // coinciding with the IDLE->START entry is carried into the new counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_en   <= 1'b0;
      busy      <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      cnt       <= '0;
      bitcnt    <= '0;
      shift     <= '0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            tick_en <= 1'b1;
            busy    <= 1'b1;
            cnt     <= tick ? CW'(1) : '0;
          end
        end
        START: begin
          if (tick) begin
            if (cnt == MID) begin
              cnt <= '0;
              if (rx_s) begin
                state   <= IDLE;
                tick_en <= 1'b0;
                busy    <= 1'b0;
              end else begin
                state  <= DATA;
                bitcnt <= '0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (cnt == LAST) begin
              cnt    <= '0;
              shift  <= {rx_s, shift[DATA_BITS-1:1]};
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt == LAST_BIT) state <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (cnt == LAST) begin
              cnt     <= '0;
              tick_en <= 1'b0;
              if (rx_s) begin
                data  <= shift;
                valid <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          tick_en <= 1'b0;
          busy    <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed + randomized bench for uart_rx_oversampled with a behavioural tick
// generator (12 MHz / 115200 baud / x8 -> tick every 13 clks) and frame model.
module tb_uart_rx_oversampled;
  localparam int DIV  = 13;
  localparam int BITC = DIV * 8;

  logic       clk = 1'b0;
  logic       rst, rx, tick, tick_en, valid, frame_err, busy;
  logic [7:0] data;
  logic       stall;
  int         gdiv;

  int total = 0, bad = 0;
  int vcnt = 0, fcnt = 0, both = 0;
  int exp_v = 0, exp_f = 0;
  logic [7:0] exp_data;

  always #5 clk = ~clk;

  // Generator held at preset phase while disabled; stall gates ticks off.
  always @(posedge clk) begin
    if (!tick_en) gdiv <= 0;
    else          gdiv <= (gdiv == DIV-1) ? 0 : gdiv + 1;
  end
  assign tick = tick_en && (gdiv == DIV-1) && !stall;

  uart_rx_oversampled dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .tick_en   (tick_en),
    .tick      (tick),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (valid)              vcnt++;
    if (frame_err)          fcnt++;
    if (valid && frame_err) both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Drives start + 8 data bits + stop; leaves rx at the stop level.
  // stall_bit gates ticks for 1000 clks inside that bit and stretches it to match.
  // rst_bit pulses reset inside that bit and returns the line high.
  task automatic send(input logic [7:0] b, input logic stop, input int stall_bit, input int rst_bit);
    int v0;
    hold(1'b0, BITC);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) begin
        hold(b[i], 30);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end else if (i == stall_bit) begin
        hold(b[i], 30);
        v0 = vcnt;
        stall = 1'b1;
        repeat (1000) @(negedge clk);
        check("stall_busy", busy, 1);
        check("stall_no_valid", vcnt, v0);
        stall = 1'b0;
        repeat (BITC - 30) @(negedge clk);
      end else begin
        hold(b[i], BITC);
      end
    end
    hold(stop, BITC);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  // Full frame followed by an idle-high gap, with model update.
  task automatic frame(input logic [7:0] b, input logic stop, input int stall_bit);
    send(b, stop, stall_bit, -1);
    hold(1'b1, 20);
    if (stop) begin exp_v++; exp_data = b; end
    else      exp_f++;
    wait_idle();
    check("frame_valid_cnt", vcnt, exp_v);
    check("frame_ferr_cnt", fcnt, exp_f);
    check("frame_data", data, exp_data);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    rst = 1'b1; rx = 1'b1; stall = 1'b0; exp_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_tick_en", tick_en, 0);
    rst = 1'b0;
    hold(1'b1, 20);
    check("idle_tick_en", tick_en, 0);

    frame(8'hA5, 1'b1, -1);

    // Short glitch: low for two tick periods only.
    hold(1'b0, 10);
    check("glitch_busy_hi", busy, 1);
    check("glitch_tick_en_hi", tick_en, 1);
    hold(1'b0, 2*DIV - 10);
    hold(1'b1, 150);
    check("glitch_busy_lo", busy, 0);
    check("glitch_valid", vcnt, exp_v);
    check("glitch_ferr", fcnt, exp_f);

    // Framing error followed by a held-low break.
    send(8'h3C, 1'b0, -1, -1);
    exp_f++;
    hold(1'b0, 40*BITC);
    check("brk_ferr_cnt", fcnt, exp_f);
    check("brk_valid_cnt", vcnt, exp_v);
    check("brk_busy", busy, 1);
    check("brk_tick_en", tick_en, 0);
    check("brk_data_kept", data, 8'hA5);
    hold(1'b1, 20);
    check("brk_exit_busy", busy, 0);
    frame(8'h55, 1'b1, -1);

    // Back-to-back frames, stop bit straight into the next start bit.
    send(8'h00, 1'b1, -1, -1);
    exp_v++;
    check("b2b_first_cnt", vcnt, exp_v);
    check("b2b_first_data", data, 8'h00);
    frame(8'hFF, 1'b1, -1);

    // Reset mid-frame at bit 4.
    send(8'h81, 1'b1, -1, 4);
    exp_data = 8'h00;
    check("mid_rst_data", data, 8'h00);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tick_en", tick_en, 0);
    hold(1'b1, 300);
    check("mid_rst_no_valid", vcnt, exp_v);
    check("mid_rst_still_idle", busy, 0);
    frame(8'h81, 1'b1, -1);

    // Tick stall during a data bit.
    frame(8'hC3, 1'b1, 3);

    // Random bytes, mostly good stop bits.
    for (int k = 0; k < 8; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      frame(rb, rs, -1);
    end

    check("never_both", both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
